md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//   Sequences the multiply/divide resource in the E stage of the P7 MIPS pipeline.
//   Owns the HI/LO registers, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E,
//   models the fixed multi-cycle latency, and drives E_HILObusy to the stall unit.
//   Honours the CP0 exception request so that a flushed E instruction never starts or commits.
// PARAMETERS
//   MUL_CYCLES  5   busy cycles after the start cycle for MULT/MULTU (range 1..15)
//   DIV_CYCLES  10  busy cycles after the start cycle for DIV/DIVU (range 1..15)
// PORTS
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   E_start    in   1   E-stage instruction is an md op (valid for one cycle per instruction)
//   E_mdop     in   3   op code (`MD_MULT,`MD_MULTU,`MD_DIV,`MD_DIVU,`MD_MTHI,`MD_MTLO)
//   E_A        in   32  rs operand (forwarded)
//   E_B        in   32  rt operand (forwarded)
//   Req        in   1   exception/interrupt taken this cycle; E instruction is being flushed
//   E_HILObusy out  1   E_start&(mult/div op)&~Req | running; combinational
//   HI         out  32  current HI register
//   LO         out  32  current LO register
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, HI=LO=0, latched operands=0, E_HILObusy=0.
//   FSM states: IDLE, RUN_MUL, RUN_DIV; running = (state != IDLE).
//   IDLE, E_start&~Req, mult op: latch A,B,op; cnt<=MUL_CYCLES; ->RUN_MUL.
//   IDLE, E_start&~Req, div op: latch A,B,op; cnt<=DIV_CYCLES; ->RUN_DIV.
//   IDLE, E_start&~Req, MTHI/MTLO: HI/LO<=E_A at this edge; stays IDLE; E_HILObusy=0.
//   RUN_*: cnt decrements every edge; on the edge where cnt==1, commit HI/LO and ->IDLE.
//   Latency: start in cycle 0; E_HILObusy high cycles 0..N; new HI/LO visible, busy low, in cycle N+1.
//   HI/LO are unchanged while RUN_*; MFHI/MFLO must stall on busy (stall unit responsibility).
//   Arithmetic: MULT {HI,LO}=$signed(A)*$signed(B) (64-bit); MULTU unsigned.
//   DIV LO=$signed(A)/$signed(B), HI=$signed(A)%$signed(B) (remainder takes sign of A); DIVU unsigned.
//   DIV/DIVU by zero: HI/LO left unchanged; 0x80000000/-1 gives LO=0x80000000, HI=0.
//   Req in the start cycle: start ignored entirely; no busy, no latch, no HI/LO write.
//   Req while RUN_*: ignored; the op already left E and completes normally.
//   E_start while RUN_* (stall-unit violation): ignored, no effect on the running op.
//   Reset mid-operation: immediate abort; result discarded; HI=LO=0.
// CONFIGURATION
//   MDU_DIV0_FAST_EN defined: DIV/DIVU with E_B==0 is accepted but never enters RUN_DIV;
//     busy only in the start cycle; HI/LO unchanged.
//   MDU_DIV0_FAST_EN undefined: div-by-zero runs the full DIV_CYCLES, then commits nothing.
// STRUCTURE
//   Shared package (Define.v): `MD_* op encodings, MDU state encodings; the default
//     MUL_CYCLES/DIV_CYCLES are also the package's latency constants for the stall unit.
//   No sub-module: FSM, down-counter, operand latches and inline arithmetic in one file.
// TESTING
//   MULT A=0xFFFFFFFD B=7 -> busy cycles 0..5; cycle 6 HI=0xFFFFFFFF LO=0xFFFFFFEB.
//   DIVU A=100 B=7 -> busy cycles 0..10; cycle 11 LO=14 HI=2; DIV A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//   MULT start with Req=1 -> busy only combinationally in cycle 0 is 0; HI/LO unchanged; state IDLE.
//   MTHI A=0x12345678 while IDLE -> HI=0x12345678 next cycle, busy never high; MTLO likewise for LO.
//   DIVU started, reset asserted async in cycle 4 -> busy 0 and HI=LO=0 at once, no later commit.
//   DIV B=0 with HI=LO=0xAA prior -> HI/LO stay 0xAA; busy cycles 0..10 (undefined) / cycle 0 only (defined).

Source files
------------

// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the multiply/divide scheduler in the E stage.
// Contents:
//   md_op_e        - md operation encodings seen on E_mdop
//   md_state_e     - scheduler FSM states
//   MUL_CYCLES_DEF - default busy cycles after start for MULT/MULTU; the
//                    stall unit uses the same constant
//   DIV_CYCLES_DEF - default busy cycles after start for DIV/DIVU
//   is_mul/is_div  - op classification helpers
package md_scheduler_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_MUL = 2'd1,
    ST_RUN_DIV = 2'd2
  } md_state_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  function automatic logic is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// E-stage <-> multiply/divide scheduler connection.
// Signals:
//   E_start    - E-stage instruction is an md op (one cycle per instruction)
//   E_mdop     - md operation code
//   E_A, E_B   - forwarded rs / rt operands
//   Req        - exception/interrupt taken; the E instruction is flushed
//   E_HILObusy - scheduler busy, goes to the stall unit
//   HI, LO     - current HI/LO register values
// Modports: master = E stage / pipeline side, slave = scheduler.
interface md_scheduler_if;
  import md_scheduler_pkg::*;

  logic        E_start;
  md_op_e      E_mdop;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        Req;
  logic        E_HILObusy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_mdop, E_A, E_B, Req,
    input  E_HILObusy, HI, LO
  );

  modport slave (
    input  E_start, E_mdop, E_A, E_B, Req,
    output E_HILObusy, HI, LO
  );

endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler for the E stage of the P7 pipeline.
// Owns HI/LO, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, models the fixed
// multi-cycle latency and reports busy to the stall unit. A flushed E
// instruction (Req in its start cycle) never starts or writes HI/LO.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high, clears all state
//   md    - md_scheduler_if.slave (E-stage request, busy, HI, LO)
// Parameters: MUL_CYCLES, DIV_CYCLES (1..15) busy cycles after start.
// Configuration macro MDU_DIV0_FAST_EN: when defined, DIV/DIVU by zero is
// accepted without entering RUN_DIV (busy in the start cycle only); when
// undefined it runs the full divide latency and then commits nothing.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave md
);

  md_state_e   state;
  logic [3:0]  cnt;
  md_op_e      op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divisor;

  // Busy is combinational so the stall unit sees it in the start cycle.
  assign md.E_HILObusy = (md.E_start & (is_mul(md.E_mdop) | is_div(md.E_mdop)) & ~md.Req)
                       | (state != ST_IDLE);
  assign md.HI = hi;
  assign md.LO = lo;

  // Results from the latched operands. The divisor is forced non-zero so
  // the divider never sees zero; a zero-divisor result is never committed.
  // The most-negative / -1 overflow case is pinned explicitly.
  always_comb begin
    divisor = (op_b == 32'd0) ? 32'd1 : op_b;
    if (op == MD_MULTU)
      prod = {32'd0, op_a} * {32'd0, op_b};
    else
      prod = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    if (op == MD_DIVU) begin
      quo = op_a / divisor;
      rem = op_a % divisor;
    end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end else begin
      quo = 32'($signed(op_a) / $signed(divisor));
      rem = 32'($signed(op_a) % $signed(divisor));
    end
  end

  // FSM with down-counter: start latches operands, RUN_* counts down and
  // commits on the edge where cnt reaches 1. E_start and Req are ignored
  // while running because the running op has already left E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      op    <= MD_MULT;
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.E_start && !md.Req) begin
            if (is_mul(md.E_mdop)) begin
              op    <= md.E_mdop;
              op_a  <= md.E_A;
              op_b  <= md.E_B;
              cnt   <= 4'(MUL_CYCLES);
              state <= ST_RUN_MUL;
            end else if (is_div(md.E_mdop)) begin
`ifdef MDU_DIV0_FAST_EN
              if (md.E_B != 32'd0) begin
                op    <= md.E_mdop;
                op_a  <= md.E_A;
                op_b  <= md.E_B;
                cnt   <= 4'(DIV_CYCLES);
                state <= ST_RUN_DIV;
              end
`else
              op    <= md.E_mdop;
              op_a  <= md.E_A;
              op_b  <= md.E_B;
              cnt   <= 4'(DIV_CYCLES);
              state <= ST_RUN_DIV;
`endif
            end else if (md.E_mdop == MD_MTHI) begin
              hi <= md.E_A;
            end else if (md.E_mdop == MD_MTLO) begin
              lo <= md.E_A;
            end
          end
        end
        ST_RUN_MUL, ST_RUN_DIV: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            if (state == ST_RUN_MUL) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (op_b != 32'd0) begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler (default MUL_CYCLES=5, DIV_CYCLES=10).
// The driver applies one set of inputs per cycle and pushes the expected
// busy/HI/LO for that cycle into a scoreboard queue; the monitor pops and
// compares on every falling edge. Expected values are hand-computed.
module tb_md_scheduler;
  import md_scheduler_pkg::*;

  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  md_scheduler_if mdi ();

  md_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one expected entry against the DUT outputs.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (mdi.E_HILObusy !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s busy: got %0b expected %0b", e.name, mdi.E_HILObusy, e.busy);
    end
    checks++;
    if (mdi.HI !== e.hi) begin
      errors++;
      $display("[TB] FAIL %s HI: got %08h expected %08h", e.name, mdi.HI, e.hi);
    end
    checks++;
    if (mdi.LO !== e.lo) begin
      errors++;
      $display("[TB] FAIL %s LO: got %08h expected %08h", e.name, mdi.LO, e.lo);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected during that cycle.
  task automatic applyStimulus(input logic rst, input logic start, input md_op_e op,
                               input logic [31:0] a, input logic [31:0] b, input logic req,
                               input logic exp_busy, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    mdi.E_start = start;
    mdi.E_mdop  = op;
    mdi.E_A     = a;
    mdi.E_B     = b;
    mdi.Req     = req;
    e.busy = exp_busy;
    e.hi   = exp_hi;
    e.lo   = exp_lo;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic idleCycles(input int n, input logic exp_busy, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input string name);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, exp_busy, exp_hi, exp_lo, name);
  endtask

  // Monitor: pops and checks one scoreboard entry per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    reset       = 1'b1;
    mdi.E_start = 1'b0;
    mdi.E_mdop  = MD_MULT;
    mdi.E_A     = 32'd0;
    mdi.E_B     = 32'd0;
    mdi.Req     = 1'b0;

    @(posedge clk);
    #1;
    e.busy = 1'b0; e.hi = 32'd0; e.lo = 32'd0; e.name = "reset";
    sb.push_back(e);

    // MULT -3 * 7, with a stray E_start and a Req during the run.
    applyStimulus(0, 1, MD_MULT, 32'hFFFF_FFFD, 32'd7, 0, 1, 32'd0, 32'd0, "mult_start");
    idleCycles(1, 1, 32'd0, 32'd0, "mult_run");
    applyStimulus(0, 1, MD_MTHI, 32'h5555_5555, 32'd0, 0, 1, 32'd0, 32'd0, "mult_stray_start");
    applyStimulus(0, 0, MD_MULT, 32'd0, 32'd0, 1, 1, 32'd0, 32'd0, "mult_req_run");
    idleCycles(2, 1, 32'd0, 32'd0, "mult_run");
    idleCycles(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_done");

    // DIVU 100 / 7.
    applyStimulus(0, 1, MD_DIVU, 32'd100, 32'd7, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "divu_start");
    idleCycles(10, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "divu_run");
    idleCycles(1, 0, 32'd2, 32'd14, "divu_done");

    // DIV -7 / 2: remainder takes the sign of the dividend.
    applyStimulus(0, 1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'd2, 32'd14, "div_start");
    idleCycles(10, 1, 32'd2, 32'd14, "div_run");
    idleCycles(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_done");

    // MULT flushed by Req in its start cycle: nothing happens.
    applyStimulus(0, 1, MD_MULT, 32'd3, 32'd3, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "mult_req_start");
    idleCycles(7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "mult_req_after");

    // MTHI / MTLO, plus an MTHI flushed by Req.
    applyStimulus(0, 1, MD_MTHI, 32'h1234_5678, 32'd0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "mthi");
    applyStimulus(0, 1, MD_MTLO, 32'h9ABC_DEF0, 32'd0, 0, 0, 32'h1234_5678, 32'hFFFF_FFFD, "mtlo");
    applyStimulus(0, 1, MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, "mthi_req");
    idleCycles(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, "mthi_req_after");

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF.
    applyStimulus(0, 1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, "multu_start");
    idleCycles(5, 1, 32'h1234_5678, 32'h9ABC_DEF0, "multu_run");
    idleCycles(1, 0, 32'hFFFF_FFFE, 32'h0000_0001, "multu_done");

    // DIV overflow 0x80000000 / -1.
    applyStimulus(0, 1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001, "div_ovf_start");
    idleCycles(10, 1, 32'hFFFF_FFFE, 32'h0000_0001, "div_ovf_run");
    idleCycles(1, 0, 32'd0, 32'h8000_0000, "div_ovf_done");

    // DIV by zero with HI=LO=0xAA.
    applyStimulus(0, 1, MD_MTHI, 32'hAA, 32'd0, 0, 0, 32'd0, 32'h8000_0000, "mthi_aa");
    applyStimulus(0, 1, MD_MTLO, 32'hAA, 32'd0, 0, 0, 32'hAA, 32'h8000_0000, "mtlo_aa");
    applyStimulus(0, 1, MD_DIV, 32'd5, 32'd0, 0, 1, 32'hAA, 32'hAA, "div0_start");
`ifdef MDU_DIV0_FAST_EN
    idleCycles(12, 0, 32'hAA, 32'hAA, "div0_after");
`else
    idleCycles(10, 1, 32'hAA, 32'hAA, "div0_run");
    idleCycles(2, 0, 32'hAA, 32'hAA, "div0_done");
`endif

    // DIVU aborted by reset in cycle 4: no later commit.
    applyStimulus(0, 1, MD_DIVU, 32'd100, 32'd7, 0, 1, 32'hAA, 32'hAA, "abort_start");
    idleCycles(3, 1, 32'hAA, 32'hAA, "abort_run");
    applyStimulus(1, 0, MD_MULT, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, "abort_reset");
    idleCycles(12, 0, 32'd0, 32'd0, "abort_after");

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
